// File: rtl/sram_ctrl.sv
// -----------------------------------------------------------------------------
// sram_ctrl
//
// Single-outstanding request/response front end for a synchronous single-port
// SRAM. Reads, full-word writes, byte-masked writes (read-modify-write) and
// empty-mask writes each take a fixed number of cycles. One response is
// produced per accepted request.
//
// Parameters
//   ADDR   SRAM word-address width
//   WIDTH  data width, a multiple of 8; WIDTH/8 byte lanes
//
// Ports
//   clk        rising-edge clock
//   res        synchronous active-high reset
//   req_valid  request present
//   req_ready  request accepted on req_valid && req_ready at a rising edge
//   req_we     1 = write, 0 = read
//   req_be     byte enables (bit i covers data[8i+7:8i]); ignored for reads
//   req_addr   word address
//   req_wdata  write data
//   rsp_valid  response present
//   rsp_ready  response consumed on rsp_valid && rsp_ready at a rising edge
//   rsp_rdata  read data; 0 for write responses
//   mem_we     SRAM write enable (registered)
//   mem_addr   SRAM address (registered)
//   mem_din    SRAM write data (registered)
//   mem_dout   SRAM read data, valid the cycle after a WE=0 address cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module sram_ctrl #(
    parameter int ADDR  = 8,
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               res,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WIDTH/8-1:0] req_be,
    input  logic [ADDR-1:0]    req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               mem_we,
    output logic [ADDR-1:0]    mem_addr,
    output logic [WIDTH-1:0]   mem_din,
    input  logic [WIDTH-1:0]   mem_dout
);

    localparam int NB = WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_WAIT,
        WR,
        RMW_RD,
        RMW_WAIT,
        RMW_WR,
        RESP
    } state_t;

    state_t state, state_d;

    // Request fields that are still needed after acceptance. The address does
    // not need its own copy: mem_addr is loaded on acceptance and only changes
    // again on the next acceptance, so it carries the address for the whole
    // transaction.
    logic [NB-1:0]    lat_be;
    logic [WIDTH-1:0] lat_wdata;
    logic             lat_load;

    logic             mem_we_d;
    logic [ADDR-1:0]  mem_addr_d;
    logic [WIDTH-1:0] mem_din_d;
    logic             rsp_valid_d;
    logic [WIDTH-1:0] rsp_rdata_d;
    logic [WIDTH-1:0] merged;
    logic             accept;

    assign req_ready = (state == IDLE) && !res;
    assign accept    = req_valid && req_ready;

    // Byte-lane merge for partial writes: enabled lanes come from the latched
    // write data, the rest keep the word just read from the SRAM.
    always_comb begin
        merged = mem_dout;
        for (int i = 0; i < NB; i++) begin
            if (lat_be[i]) begin
                merged[8*i +: 8] = lat_wdata[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic. All SRAM-facing outputs and the
    // response outputs are registered, so this block computes their next
    // values alongside the next state.
    always_comb begin
        state_d     = state;
        lat_load    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_din_d   = mem_din;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;

        case (state)
            IDLE: begin
                if (accept) begin
                    lat_load    = 1'b1;
                    mem_addr_d  = req_addr;
                    // Write responses carry zero data; reads overwrite this
                    // when the SRAM word arrives.
                    rsp_rdata_d = '0;
                    if (!req_we) begin
                        state_d = RD;
                    end else if (&req_be) begin
                        state_d   = WR;
                        mem_we_d  = 1'b1;
                        mem_din_d = req_wdata;
                    end else if (|req_be) begin
                        state_d = RMW_RD;
                    end else begin
                        // Empty mask: nothing to store, answer immediately.
                        state_d = RESP;
                    end
                end
            end

            RD: begin
                state_d = RD_WAIT;
            end

            RD_WAIT: begin
                rsp_rdata_d = mem_dout;
                state_d     = RESP;
            end

            WR: begin
                state_d = RESP;
            end

            RMW_RD: begin
                state_d = RMW_WAIT;
            end

            RMW_WAIT: begin
                mem_din_d = merged;
                mem_we_d  = 1'b1;
                state_d   = RMW_WR;
            end

            RMW_WR: begin
                state_d = RESP;
            end

            RESP: begin
                // rsp_valid rises one cycle after entering RESP, so the
                // handshake can never occur in the entry cycle.
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else begin
            state     <= state_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_din   <= mem_din_d;
            if (lat_load) begin
                lat_be    <= req_be;
                lat_wdata <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
`timescale 1ns/1ps

module tb_sram_ctrl;

    logic        clk;
    logic        res;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    sram_ctrl #(.ADDR(8), .WIDTH(32)) dut (
        .clk       (clk),
        .res       (res),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_be    (req_be),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: write on WE, registered read of the presented address.
    logic [31:0] sram [0:255];
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_din;
        mem_dout <= sram[mem_addr];
    end

    int pulses = 0;
    always @(posedge clk) if (mem_we === 1'b1) pulses++;

    int nvec = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        longint      t_first;
    } exp_t;
    exp_t q[$];

    // Monitor: samples 2 ns after each falling edge, well clear of both edges.
    logic prev_v = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (rsp_valid === 1'b1 && !prev_v) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                chk("rsp_latency", 32'(longint'($time) - 7), 32'(q[0].t_first));
            end
        end
        if (rsp_valid === 1'b1 && rsp_ready && q.size() > 0) begin
            chk("rsp_rdata", rsp_rdata, q[0].rdata);
            void'(q.pop_front());
        end
        prev_v = (rsp_valid === 1'b1);
    end

    task automatic wait_ready();
        int k = 0;
        while (req_ready !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // Issue one request, push its expected response, scramble the inputs after
    // acceptance, wait for the response and check the number of SRAM writes.
    task automatic do_req(input logic we, input logic [3:0] be, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp, input int lat,
                          input int exp_pulses);
        exp_t e;
        int   p0;
        int   k;
        wait_ready();
        p0        = pulses;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        e.rdata   = exp;
        e.t_first = longint'($time) + 10 * lat;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = ~we;
        req_be    = ~be;
        req_addr  = ~addr;
        req_wdata = ~wd;
        k = 0;
        while (q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_timeout", 32'(q.size()), 32'd0);
        q.delete();
        @(negedge clk);
        chk("mem_we_pulses", 32'(pulses - p0), 32'(exp_pulses));
    endtask

    initial begin
        int k;
        exp_t e;
        int p0;

        res       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 8'h00;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;

        // Reset held for two edges: every output at zero, not ready.
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
            chk("rst_mem_we",    {31'd0, mem_we}, 32'd0);
            chk("rst_mem_addr",  {24'd0, mem_addr}, 32'd0);
            chk("rst_mem_din",   mem_din, 32'd0);
        end
        res = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // Full write then read back.
        do_req(1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 32'h0, 2, 1);
        do_req(1'b0, 4'h0, 8'h10, 32'h0, 32'hDEADBEEF, 3, 0);

        // Partial write merges lanes 0 and 2 from new data.
        do_req(1'b1, 4'hF, 8'h20, 32'h11223344, 32'h0, 2, 1);
        do_req(1'b1, 4'b0101, 8'h20, 32'hAABBCCDD, 32'h0, 4, 1);
        do_req(1'b0, 4'h0, 8'h20, 32'h0, 32'h11BB33DD, 3, 0);

        // Empty mask: no SRAM write, data untouched.
        do_req(1'b1, 4'hF, 8'h30, 32'h55AA55AA, 32'h0, 2, 1);
        do_req(1'b1, 4'h0, 8'h30, 32'hFFFFFFFF, 32'h0, 1, 0);
        do_req(1'b0, 4'hF, 8'h30, 32'h0, 32'h55AA55AA, 3, 0);

        // Address extremes and a top-lane-only partial write.
        do_req(1'b1, 4'hF, 8'hFF, 32'hA5A5A5A5, 32'h0, 2, 1);
        do_req(1'b1, 4'hF, 8'h00, 32'h01020304, 32'h0, 2, 1);
        do_req(1'b0, 4'h0, 8'hFF, 32'h0, 32'hA5A5A5A5, 3, 0);
        do_req(1'b1, 4'b1000, 8'h00, 32'h77665544, 32'h0, 4, 1);
        do_req(1'b0, 4'h0, 8'h00, 32'h0, 32'h77020304, 3, 0);
        do_req(1'b1, 4'b0110, 8'hFF, 32'h00C3D200, 32'h0, 4, 1);
        do_req(1'b0, 4'h0, 8'hFF, 32'h0, 32'hA5C3D2A5, 3, 0);

        // Back-pressured read: response holds, new requests ignored.
        wait_ready();
        p0        = pulses;
        rsp_ready = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'h0;
        req_addr  = 8'h10;
        req_valid = 1'b1;
        @(posedge clk);
        e.rdata   = 32'hDEADBEEF;
        e.t_first = longint'($time) + 30;
        q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (rsp_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("stall_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            req_valid = i[0];
            req_we    = 1'b1;
            req_be    = 4'hF;
            req_addr  = 8'h20;
            req_wdata = 32'h0BADF00D;
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
        chk("stall_queue", 32'(q.size()), 32'd0);
        q.delete();
        chk("stall_pulses", 32'(pulses - p0), 32'd0);
        do_req(1'b0, 4'h0, 8'h20, 32'h0, 32'h11BB33DD, 3, 0);

        // Reset during RMW_WAIT aborts the partial write.
        do_req(1'b1, 4'hF, 8'h40, 32'hCAFEF00D, 32'h0, 2, 1);
        wait_ready();
        p0        = pulses;
        req_we    = 1'b1;
        req_be    = 4'b0011;
        req_addr  = 8'h40;
        req_wdata = 32'h12345678;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        res = 1'b1;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("midrst_mem_we",    {31'd0, mem_we}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_mem_addr",  {24'd0, mem_addr}, 32'd0);
        chk("midrst_mem_din",   mem_din, 32'd0);
        res = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_rsp_idle",  {31'd0, rsp_valid}, 32'd0);
        chk("midrst_pulses",    32'(pulses - p0), 32'd0);
        do_req(1'b0, 4'h0, 8'h40, 32'h0, 32'hCAFEF00D, 3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs + 1);
        $fatal(1);
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR, default 8, SRAM word-address width.
REQ-002 SHALL have parameter WIDTH, default 32, data width; multiple of 8; NB = WIDTH/8 byte lanes.
REQ-003 SHALL have port clk  in  1  rising-edge clock.
REQ-004 SHALL have port res  in  1  reset; one clock; synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  request present.
REQ-006 SHALL have port req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
REQ-007 SHALL have port req_we  in  1  1 = write, 0 = read.
REQ-008 SHALL have port req_be  in  NB  byte enables; bit i covers data[8i+7:8i]; ignored for reads.
REQ-009 SHALL have port req_addr  in  ADDR  word address.
REQ-010 SHALL have port req_wdata  in  WIDTH  write data.
REQ-011 SHALL have port rsp_valid  out  1  response present.
REQ-012 SHALL have port rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
REQ-013 SHALL have port rsp_rdata  out  WIDTH  read data; 0 for write responses.
REQ-014 SHALL have ports mem_we out 1, mem_addr out ADDR, mem_din out WIDTH; all registered; drive the SRAM WE/addr/data_in.
REQ-015 SHALL have port mem_dout  in  WIDTH  SRAM data_out; valid in the cycle after a WE=0 cycle presenting the address.

Function
REQ-016 SHALL implement states IDLE, RD, RD_WAIT, WR, RMW_RD, RMW_WAIT, RMW_WR, RESP.
REQ-017 SHALL assert req_ready only in IDLE with res low; one outstanding request max.
REQ-018 SHALL latch addr/we/be/wdata on acceptance; later input changes have no effect.
REQ-019 Read, accepted at edge N: RD (mem_we=0, mem_addr=addr) -> RD_WAIT -> capture mem_dout into rsp_rdata at edge N+2; rsp_valid high from edge N+3.
REQ-020 Write with be all ones: WR (mem_we=1, mem_din=wdata) for exactly one cycle; rsp_valid high from edge N+2.
REQ-021 Write with 0 < be < all ones: RMW_RD (mem_we=0) -> RMW_WAIT (merge: lane i = be[i] ? wdata lane : mem_dout lane, registered into mem_din) -> RMW_WR (mem_we=1, one cycle) -> RESP; rsp_valid high from edge N+4.
REQ-022 Write with be = 0: no SRAM access, mem_we stays 0; RESP directly; rsp_valid high from edge N+1.
REQ-023 SHALL hold mem_we = 0 in every state other than WR and RMW_WR; mem_addr/mem_din hold last value when idle.
REQ-024 RESP: rsp_valid = 1, rsp_rdata stable until handshake; on rsp_valid && rsp_ready -> IDLE, rsp_valid = 0 next cycle.
REQ-025 SHALL not accept a new request in the handshake cycle of RESP; earliest next accept is the cycle after.
REQ-026 All address values 0 .. 2^ADDR-1 SHALL be legal; no wrap or range checking.

Reset
REQ-027 While res is high at an edge: state <= IDLE, rsp_valid <= 0, rsp_rdata <= 0, mem_we <= 0, mem_addr <= 0, mem_din <= 0.
REQ-028 req_ready SHALL be 0 in any cycle with res high; 1 in the first cycle after res falls.
REQ-029 Reset mid-operation SHALL abort the transaction and discard its response; a write whose mem_we=1 cycle coincides with res still commits in the SRAM; no later mem_we pulse occurs.

Verification
REQ-030 Reset: res high 2 cycles -> all outputs 0, req_ready 0; res low -> req_ready 1 next cycle.
REQ-031 Write 0xDEADBEEF to 0x10, be=4'hF, then read 0x10 -> one mem_we pulse, write rsp at N+2; read rsp at N+3, rsp_rdata = 0xDEADBEEF.
REQ-032 Word 0x11223344 at 0x20; write be=4'b0101, wdata=0xAABBCCDD -> rsp at N+4; readback 0x11BB33DD.
REQ-033 Read with rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0, req_valid pulses ignored; rsp_ready high -> IDLE next cycle.
REQ-034 Write be=0 to 0x30 holding 0x55AA55AA -> no mem_we pulse, rsp at N+1, readback 0x55AA55AA.
REQ-035 Partial write to 0x40, res high during RMW_WAIT -> mem_we never asserts, rsp_valid 0, 0x40 unchanged.
